mux_n_to_1_seq: RTL
===================

Name: mux_n_to_1_seq

Overview:
Parametrised, registered N-to-1 multiplexer; successor to the combinational 2-to-1 mux in Level3/MUX.
Selects one of CHANNELS WIDTH-bit inputs in one of two modes:
- Manual: the channel is chosen through a request/acknowledge handshake.
- Auto-scan: channels are time-multiplexed with a fixed dwell, for display digit scanning in the microwave front panel.
Every channel switch passes through a blanking gap so downstream logic never sees a mixed or glitched value.

Parameters:
WIDTH, 4, bit width of each data channel
CHANNELS, 4, number of input channels (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= CHANNELS
GAP, 1, blanking cycles inserted on every channel switch (0 allowed)
DWELL, 1000, cycles each channel is held in scan mode (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  CHANNELS*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH]
sel_in  input  SEL_W  requested channel (manual mode)
sel_req  input  1  select request, sampled on clk
scan_en  input  1  1 = auto-scan mode, 0 = manual mode
q  output  WIDTH  registered selected data
q_valid  output  1  q holds data of cur_sel
cur_sel  output  SEL_W  currently selected channel
sel_ack  output  1  one-cycle pulse: manual switch completed
sel_err  output  1  one-cycle pulse: request rejected (sel_in >= CHANNELS)

Behaviour:
- Reset (asynchronous, immediate on rst_n low, even mid-operation):
  - state=HOLD; q=0, q_valid=0, cur_sel=0, sel_ack=0, sel_err=0; dwell and gap counters=0.
  - First clock edge after release: q<=data_in[ch0], q_valid<=1.
- States: HOLD, BLANK, SCAN_HOLD (BLANK is shared by both modes).
- HOLD (manual), each edge: q<=data_in[cur_sel], q_valid<=1. q tracks input changes with 1-cycle latency.
- Manual request, at edge E0 in HOLD with scan_en=0 and sel_req=1:
  - sel_in < CHANNELS and GAP>0: latch sel_in; go to BLANK; q<=0, q_valid<=0.
  - After exactly GAP blank cycles, at edge E0+GAP: cur_sel<=latched, q<=data_in[latched], q_valid<=1, sel_ack<=1 for one cycle; return to HOLD.
  - GAP=0: the switch and sel_ack occur at E0 directly; no blank cycle.
  - sel_in >= CHANNELS: sel_err<=1 for one cycle; state, cur_sel and q unchanged.
  - sel_in == cur_sel: full blank/ack sequence still runs (uniform timing).
- sel_req while in BLANK is ignored: no ack, no err, not queued.
- scan_en=1 has priority. sel_req is ignored while scan_en=1 or in SCAN_HOLD.
- Entering scan: at the first edge with scan_en=1 in HOLD, go to SCAN_HOLD on the current channel; dwell counter restarts.
- SCAN_HOLD: q tracks data_in[cur_sel] with q_valid=1. After DWELL cycles, go to BLANK for GAP cycles, then next=(cur_sel==CHANNELS-1)?0:cur_sel+1.
  - sel_ack is never pulsed in scan mode.
- Leaving scan: scan_en=0 in SCAN_HOLD returns to HOLD on the next edge, keeping cur_sel. If deasserted during BLANK, the blank completes, the advance happens, then HOLD.
- Dwell counter width: clog2(DWELL+1). No overflow: it reloads on every switch.

Test Plan:
(CHANNELS=4, WIDTH=4, GAP=2, DWELL=5; data_in ch3..ch0 = D,C,B,A.)
1. Reset: hold rst_n=0 -> q=0, q_valid=0, cur_sel=0. Release -> next edge q=A, q_valid=1. Assert rst_n=0 between edges mid-BLANK -> outputs zero immediately.
2. Manual switch: sel_in=2, sel_req pulse at E0 -> q=0/q_valid=0 for 2 cycles; at E0+2 cur_sel=2, q=C, sel_ack=1 for exactly one cycle. Then change ch2 to 5 -> q=5 one cycle later.
3. Error/ignored requests: CHANNELS=3 build, sel_in=3 -> sel_err pulse, q/cur_sel unchanged. sel_req during BLANK -> no ack, no err, cur_sel ends at the first request's value.
4. Scan: scan_en=1 from cur_sel=0 -> sequence A×5, 0(invalid)×2, B×5, gap, C, gap, D, gap, A (wrap). sel_req pulses meanwhile are ignored and sel_ack stays 0.
5. GAP=0 build: sel_req sel_in=3 -> q=D and sel_ack=1 at the very next edge; q_valid never drops.
6. Scan exit: drop scan_en during BLANK after ch1 -> cur_sel=2, HOLD, q=C stable beyond DWELL cycles.

Source files
------------

// File: rtl/mux_n_to_1_seq.sv
`default_nettype none
// ============================================================================
// mux_n_to_1_seq : registered N-to-1 mux with manual handshake and auto-scan,
//                  blanking every channel switch.
// Revision 1.0
// ============================================================================
module mux_n_to_1_seq #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int GAP      = 1,
  parameter int DWELL    = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      sel_req,
  input  logic                      scan_en,
  output logic [WIDTH-1:0]          q,
  output logic                      q_valid,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      sel_ack,
  output logic                      sel_err
);

  localparam int c_dwell_w = $clog2(DWELL + 1);
  localparam int c_gap_w   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [SEL_W:0]       c_channels   = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0]     c_last       = SEL_W'(CHANNELS - 1);
  localparam logic [c_gap_w-1:0]   c_gap_load   = (GAP > 0) ? c_gap_w'(GAP - 1) : '0;
  localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(DWELL - 1);

  typedef enum logic [1:0] {ST_HOLD, ST_BLANK, ST_SCAN_HOLD} state_t;

  // Full 2**SEL_W table so the select index width always matches; spare slots read 0.
  logic [WIDTH-1:0] w_ch [2**SEL_W];
  generate
    for (genvar k = 0; k < 2**SEL_W; k++) begin : g_ch
      if (k < CHANNELS) begin : g_used
        assign w_ch[k] = data_in[k*WIDTH +: WIDTH];
      end else begin : g_unused
        assign w_ch[k] = '0;
      end
    end
  endgenerate

  state_t                 r_state, w_state;
  logic [WIDTH-1:0]       r_q, w_q;
  logic                   r_q_valid, w_q_valid;
  logic [SEL_W-1:0]       r_cur_sel, w_cur_sel;
  logic [SEL_W-1:0]       r_pend_sel, w_pend_sel;
  logic                   r_manual, w_manual;
  logic                   r_sel_ack, w_sel_ack;
  logic                   r_sel_err, w_sel_err;
  logic [c_dwell_w-1:0]   r_dwell, w_dwell;
  logic [c_gap_w-1:0]     r_gap, w_gap;
  logic [SEL_W-1:0]       w_scan_next;

  assign w_scan_next = (r_cur_sel == c_last) ? '0 : r_cur_sel + 1'b1;

  always_comb begin
    w_state    = r_state;
    w_q        = w_ch[r_cur_sel];
    w_q_valid  = 1'b1;
    w_cur_sel  = r_cur_sel;
    w_pend_sel = r_pend_sel;
    w_manual   = r_manual;
    w_sel_ack  = 1'b0;
    w_sel_err  = 1'b0;
    w_dwell    = r_dwell;
    w_gap      = r_gap;
    case (r_state)
      ST_HOLD: begin
        if (scan_en) begin
          w_state = ST_SCAN_HOLD;
          w_dwell = '0;
        end else if (sel_req) begin
          if ({1'b0, sel_in} >= c_channels) begin
            w_sel_err = 1'b1;
          end else if (GAP == 0) begin
            w_cur_sel = sel_in;
            w_q       = w_ch[sel_in];
            w_sel_ack = 1'b1;
          end else begin
            w_state    = ST_BLANK;
            w_pend_sel = sel_in;
            w_manual   = 1'b1;
            w_gap      = c_gap_load;
            w_q        = '0;
            w_q_valid  = 1'b0;
          end
        end
      end
      ST_SCAN_HOLD: begin
        if (!scan_en) begin
          w_state = ST_HOLD;
        end else if (r_dwell == c_dwell_last) begin
          if (GAP == 0) begin
            w_cur_sel = w_scan_next;
            w_q       = w_ch[w_scan_next];
            w_dwell   = '0;
          end else begin
            w_state    = ST_BLANK;
            w_pend_sel = w_scan_next;
            w_manual   = 1'b0;
            w_gap      = c_gap_load;
            w_q        = '0;
            w_q_valid  = 1'b0;
          end
        end else begin
          w_dwell = r_dwell + 1'b1;
        end
      end
      ST_BLANK: begin
        // Requests are dropped here; the pending switch always completes.
        w_q       = '0;
        w_q_valid = 1'b0;
        if (r_gap == '0) begin
          w_cur_sel = r_pend_sel;
          w_q       = w_ch[r_pend_sel];
          w_q_valid = 1'b1;
          w_sel_ack = r_manual;
          w_dwell   = '0;
          w_state   = scan_en ? ST_SCAN_HOLD : ST_HOLD;
        end else begin
          w_gap = r_gap - 1'b1;
        end
      end
      default: w_state = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_HOLD;
      r_q        <= '0;
      r_q_valid  <= 1'b0;
      r_cur_sel  <= '0;
      r_pend_sel <= '0;
      r_manual   <= 1'b0;
      r_sel_ack  <= 1'b0;
      r_sel_err  <= 1'b0;
      r_dwell    <= '0;
      r_gap      <= '0;
    end else begin
      r_state    <= w_state;
      r_q        <= w_q;
      r_q_valid  <= w_q_valid;
      r_cur_sel  <= w_cur_sel;
      r_pend_sel <= w_pend_sel;
      r_manual   <= w_manual;
      r_sel_ack  <= w_sel_ack;
      r_sel_err  <= w_sel_err;
      r_dwell    <= w_dwell;
      r_gap      <= w_gap;
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign cur_sel = r_cur_sel;
  assign sel_ack = r_sel_ack;
  assign sel_err = r_sel_err;

endmodule
`default_nettype wire
